// File: rtl/pong_wb_regs.sv
// Pong Wishbone register block: game control, live status,
// and maskable score / game-over interrupts for firmware.
module pong_wb_regs #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE    = 32'h504F_4E47,
  parameter logic [2:0]  SPEED_RESET = 3'd2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        active,
  input  logic [3:0]  score_p1,
  input  logic [3:0]  score_p2,
  input  logic        game_over,
  output logic        game_enable,
  output logic [2:0]  game_speed,
  output logic        game_rst,
  output logic [2:0]  irq
);

  localparam logic [5:0] OFF_CTRL = 6'h00;
  localparam logic [5:0] OFF_STAT = 6'h01;
  localparam logic [5:0] OFF_IEN  = 6'h02;
  localparam logic [5:0] OFF_IST  = 6'h03;
  localparam logic [5:0] OFF_ID   = 6'h04;

  logic        hit;
  logic        rd_hit;
  logic        wr_hit;
  logic [5:0]  off;
  logic        wr_ctrl;
  logic        wr_ien;
  logic        wr_ist;
  logic [31:0] rd_data;

  logic [2:0]  irq_en;
  logic [2:0]  irq_stat;
  logic [2:0]  ev;
  logic [2:0]  clr;
  logic [3:0]  p1_q;
  logic [3:0]  p2_q;
  logic        go_q;

  logic        unused_ok;

  // A new transfer is taken only when the previous ack has retired.
  assign hit = wbs_cyc_i & wbs_stb_i & active
             & (wbs_adr_i[31:8] == BASE_ADDR[31:8])
             & ~wbs_ack_o;
  assign off     = wbs_adr_i[7:2];
  assign rd_hit  = hit & ~wbs_we_i;
  assign wr_hit  = hit & wbs_we_i;
  assign wr_ctrl = wr_hit & (off == OFF_CTRL);
  assign wr_ien  = wr_hit & (off == OFF_IEN) & wbs_sel_i[0];
  assign wr_ist  = wr_hit & (off == OFF_IST) & wbs_sel_i[0];

  assign ev  = {game_over & ~go_q,
                score_p2 != p2_q,
                score_p1 != p1_q};
  assign clr = wr_ist ? wbs_dat_i[2:0] : 3'b000;

  assign irq = irq_stat & irq_en & {3{active}};

  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:9],
                       wbs_dat_i[7:4], wbs_sel_i[3:2]};

  // Read mux for the selected offset; holes read as zero.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      off == OFF_CTRL:
        rd_data = {28'd0, game_speed, game_enable};
      off == OFF_STAT:
        rd_data = {22'd0, active, game_over,
                   score_p2, score_p1};
      off == OFF_IEN:
        rd_data = {29'd0, irq_en};
      off == OFF_IST:
        rd_data = {29'd0, irq_stat};
      off == OFF_ID:
        rd_data = ID_VALUE;
      default:
        rd_data = '0;
    endcase
  end

  // Single-cycle registered ack with read data gated by it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= rd_hit ? rd_data : '0;
    end
  end

  // Game control register and the soft-reset strobe.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      game_enable <= 1'b0;
      game_speed  <= SPEED_RESET;
      game_rst    <= 1'b0;
    end else begin
      game_rst <= wr_ctrl & wbs_sel_i[1] & wbs_dat_i[8];
      if (wr_ctrl & wbs_sel_i[0]) begin
        game_enable <= wbs_dat_i[0];
        game_speed  <= wbs_dat_i[3:1];
      end
    end
  end

  // Event history, sticky status (set beats clear) and enables.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      p1_q     <= '0;
      p2_q     <= '0;
      go_q     <= 1'b0;
      irq_en   <= '0;
      irq_stat <= '0;
    end else begin
      p1_q     <= score_p1;
      p2_q     <= score_p2;
      go_q     <= game_over;
      irq_stat <= (irq_stat & ~clr) | ev;
      if (wr_ien) begin
        irq_en <= wbs_dat_i[2:0];
      end
    end
  end

endmodule

// File: tb/tb_pong_wb_regs.sv
// Directed + randomized bench for pong_wb_regs against a
// register-level reference model of the firmware-visible state.
module tb_pong_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] IDV  = 32'h504F_4E47;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat_o;
  logic        active;
  logic [3:0]  p1, p2;
  logic        go;
  logic        g_en;
  logic [2:0]  g_spd;
  logic        g_rst;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;

  logic       m_en;
  logic [2:0] m_spd;
  logic [2:0] m_ien;
  logic [2:0] m_stat;
  logic [3:0] m_p1, m_p2;
  logic       m_go;

  always #5 clk = ~clk;

  pong_wb_regs dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat_o),
    .active     (active),
    .score_p1   (p1),
    .score_p2   (p2),
    .game_over  (go),
    .game_enable(g_en),
    .game_speed (g_spd),
    .game_rst   (g_rst),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_irq();
    return m_stat & m_ien & {3{active}};
  endfunction

  function automatic logic [31:0] exp_read(input logic [5:0] o);
    case (o)
      6'd0:    return {28'd0, m_spd, m_en};
      6'd1:    return {22'd0, 1'b1, m_go, m_p2, m_p1};
      6'd2:    return {29'd0, m_ien};
      6'd3:    return {29'd0, m_stat};
      6'd4:    return IDV;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [5:0] o, input logic [3:0] s,
                         input logic [31:0] d);
    if (s[0]) begin
      case (o)
        6'd0: begin m_en = d[0]; m_spd = d[3:1]; end
        6'd2: m_ien = d[2:0];
        6'd3: m_stat = m_stat & ~d[2:0];
        default: ;
      endcase
    end
  endtask

  // After a reset the history is zero, so nonzero inputs raise events.
  task automatic m_reset();
    m_en   = 1'b0;
    m_spd  = 3'd2;
    m_ien  = 3'd0;
    m_stat = {m_go, m_p2 != 4'd0, m_p1 != 4'd0};
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b,
                        input logic g);
    @(negedge clk);
    if (a != m_p1) m_stat[0] = 1'b1;
    if (b != m_p2) m_stat[1] = 1'b1;
    if (g && !m_go) m_stat[2] = 1'b1;
    m_p1 = a; m_p2 = b; m_go = g;
    p1 = a; p2 = b; go = g;
    @(negedge clk);
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic gr,
                      output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; sel = s; wdat = d;
    lat = 0; rd = '0; gr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i; rd = rdat_o; gr = g_rst;
        break;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [5:0] o,
                        input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    logic gr;
    int lat;
    xfer(1'b1, BASE + {24'd0, o, 2'b00}, s, d, rd, gr, lat);
    m_write(o, s, d);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_rst"}, {31'd0, gr}, {31'd0, o == 6'd0 && s[1] && d[8]});
  endtask

  task automatic rd_reg(input string tag, input logic [5:0] o);
    logic [31:0] rd;
    logic gr;
    int lat;
    xfer(1'b0, BASE + {24'd0, o, 2'b00}, 4'hF, 32'd0, rd, gr, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk(tag, rd, exp_read(o));
  endtask

  task automatic chk_outs(input string tag);
    chk(tag, {25'd0, irq, g_spd, g_en},
        {25'd0, m_irq(), m_spd, m_en});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic gr;
    int lat;
    logic [2:0] pat;

    rst = 1'b1; cyc = 0; stb = 0; we = 0;
    sel = 0; adr = 0; wdat = 0;
    active = 1'b1; p1 = 0; p2 = 0; go = 0;
    m_p1 = 0; m_p2 = 0; m_go = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat_o, 32'd0);
    chk("rst_outs", {24'd0, g_rst, irq, g_spd, g_en},
        {24'd0, 1'b0, 3'd0, 3'd2, 1'b0});
    rst = 1'b0;

    rd_reg("id", 6'd4);
    set_in(4'd3, 4'd5, 1'b0);
    rd_reg("status", 6'd1);
    chk("status_val", exp_read(6'd1), 32'h0000_0253);

    wr_reg("ctrl_w", 6'd0, 4'b0001, 32'h0000_000B);
    chk("ctrl_outs", {28'd0, g_spd, g_en}, 32'h0000_000B);
    rd_reg("ctrl_rd", 6'd0);
    wr_reg("softrst", 6'd0, 4'b0010, 32'h0000_0100);
    @(posedge clk); #1;
    chk("softrst_end", {31'd0, g_rst}, 32'd0);
    rd_reg("ctrl_keep", 6'd0);

    wr_reg("ist_clr", 6'd3, 4'b0001, 32'd7);
    wr_reg("ien_all", 6'd2, 4'b0001, 32'd7);
    chk_outs("irq_idle");
    @(negedge clk);
    p1 = 4'd4; m_p1 = 4'd4; m_stat[0] = 1'b1;
    @(posedge clk); #1;
    chk("irq_p1", {29'd0, irq}, 32'd1);
    rd_reg("ist_p1", 6'd3);
    wr_reg("ist_w1c", 6'd3, 4'b0001, 32'd1);
    chk_outs("irq_cleared");

    @(negedge clk);
    go = 1'b1; cyc = 1; stb = 1; we = 1;
    adr = BASE + 32'h0C; sel = 4'b0001; wdat = 32'd4;
    @(posedge clk); #1;
    m_go = 1'b1; m_stat[2] = 1'b1;
    chk("race_ack", {31'd0, ack}, 32'd1);
    chk_outs("race_irq");
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    rd_reg("race_ist", 6'd3);
    wr_reg("go_clr", 6'd3, 4'b0001, 32'd4);
    rd_reg("go_clr_rd", 6'd3);

    set_in(4'd4, 4'd6, 1'b1);
    @(negedge clk);
    active = 1'b0;
    @(posedge clk); #1;
    chk("inact_irq", {29'd0, irq}, 32'd0);
    set_in(4'd9, 4'd6, 1'b1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("inact_ack", {31'd0, ack}, 32'd0);
    end
    @(negedge clk);
    active = 1'b1;
    @(posedge clk); #1;
    chk("act_ack", {31'd0, ack}, 32'd1);
    chk("act_dat", rdat_o, IDV);
    chk_outs("act_irq");
    chk("act_irq_val", {29'd0, irq}, 32'd3);
    @(negedge clk);
    cyc = 0; stb = 0;

    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0110; sel = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("badbase_ack", {31'd0, ack}, 32'd0);
    end
    @(negedge clk);
    adr = BASE + 32'h10;
    #1;
    pat[0] = ack;
    @(posedge clk); #1; pat[1] = ack;
    @(posedge clk); #1; pat[2] = ack;
    @(posedge clk); #1;
    chk("stb_held", {28'd0, ack, pat[2], pat[1], pat[0]}, 32'b1010);
    @(negedge clk);
    cyc = 0; stb = 0;

    wr_reg("pre_rst", 6'd2, 4'b0001, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    cyc = 1; stb = 1; we = 1;
    adr = BASE; sel = 4'hF; wdat = 32'h0000_010F;
    @(posedge clk); #1;
    chk("rstw_ack", {31'd0, ack}, 32'd0);
    chk("rstw_ctrl", {28'd0, g_spd, g_en}, 32'h4);
    @(negedge clk);
    rst = 1'b0; cyc = 0; stb = 0; we = 0;
    m_reset();
    @(posedge clk); #1;
    chk("rstw_ack2", {31'd0, ack}, 32'd0);
    rd_reg("rst_events", 6'd3);
    chk("rst_events_val", exp_read(6'd3), 32'd7);
    rd_reg("rst_ien", 6'd2);
    chk_outs("rst_outs2");

    for (int n = 0; n < 80; n++) begin
      logic [31:0] d;
      logic [3:0] s;
      logic [5:0] o;
      d = $urandom;
      s = 4'($urandom);
      case ($urandom_range(0, 4))
        0: set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom));
        1: wr_reg("r_ctrl", 6'd0, s, d);
        2: wr_reg("r_ien", 6'd2, s, d);
        3: wr_reg("r_ist", 6'd3, s, d);
        default: begin
          o = 6'($urandom_range(0, 15));
          rd_reg("r_read", o);
        end
      endcase
      chk_outs("r_outs");
    end

    for (int o = 5; o < 8; o++) begin
      wr_reg("hole_w", 6'(o), 4'hF, 32'hFFFF_FFFF);
      rd_reg("hole_r", 6'(o));
    end
    wr_reg("ro_w", 6'd4, 4'hF, 32'h1234_5678);
    rd_reg("ro_r", 6'd4);
    chk_outs("final_outs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
